axi4_lite_reg_bank: RTL and testbench
=====================================

Name: axi4_lite_reg_bank

Overview:
- AXI4-Lite slave (responder) that terminates one 32-bit BAR interface after the 64→32 data-width translation.
- Implements a bank of NREGS 32-bit registers. Each register is either control (read/write, driven to fabric) or status (read-only, sampled from fabric).
- Generates per-register write and read strobes so user logic can react to host accesses.
- Supports one outstanding write and one outstanding read. The write and read paths are fully independent.

Parameters:
- DW, 32, data width; only 32 is supported.
- AW, 32, address width of the slave interface.
- NREGS, 16, number of registers; power of 2, range 2..256.
- RO_MASK, {NREGS{1'b0}}, bit i = 1 makes register i read-only (status) and 0 makes it read/write (control).

Ports:
- bar_clk  in  1  single clock for all logic.
- bar_rst  in  1  synchronous, active-high reset.
- s  axi4_lite_if.s  DW=32, AW=32  AXI4-Lite slave: AW/W/B/AR/R channels; awprot/arprot are ignored.
- ctrl_q  out  NREGS*DW  control register contents; register i occupies bits [i*32 +: 32].
- status_d  in  NREGS*DW  status inputs returned on reads of RO registers.
- wr_stb  out  NREGS  one-cycle pulse on the cycle a write to register i is committed.
- rd_stb  out  NREGS  one-cycle pulse on the cycle read data of register i is presented.

Behaviour:
- Decode: index = addr[log2(NREGS)+1:2]. addr[1:0] are ignored. Any set bit in addr[AW-1:log2(NREGS)+2] means out of range.
- Reset (bar_rst high at an edge): ctrl_q = 0, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0, wr_stb = rd_stb = 0, all latched AW/W state cleared.
  - awready, wready and arready are 0 while bar_rst is high.
  - In-flight transactions are dropped and produce no response.
- Write path: independent AW and W holding registers, with flags aw_full and w_full.
  - awready = !aw_full && !bvalid && !bar_rst.
  - wready = !w_full && !bvalid && !bar_rst.
  - AW and W may arrive in either order or in the same cycle. Each channel is accepted at most once per transaction.
  - Commit edge: the first edge at which both address and data are available, either latched earlier or handshaking on that edge.
  - At commit:
    - For an in-range RW target, ctrl_q[index] bytes with wstrb[k]=1 take wdata[8k+:8]; other bytes are unchanged.
    - wr_stb[index] pulses in the following cycle.
    - bvalid rises in the following cycle, and the flags clear.
  - Minimum latency: AW+W handshake at edge N gives updated ctrl_q, the wr_stb pulse and bvalid from N+1.
  - bresp values:
    - 2'b00 OKAY for an in-range RW target.
    - 2'b10 SLVERR for an RO target; no register change, no wr_stb.
    - 2'b11 DECERR for an out-of-range address; no change, no strobe.
  - bvalid and bresp are held stable until bready is sampled high. bvalid drops at that edge.
  - A new AW/W can be accepted from the cycle after B completes.
- Read path:
  - arready = !rvalid && !bar_rst.
  - On AR handshake at edge N:
    - rdata is registered as status_d[index] for RO, ctrl_q[index] for RW, or 0 for out-of-range.
    - rresp is 00, or 11 for out-of-range.
    - rvalid and rd_stb[index] (in-range only) assert at N+1.
  - rdata, rresp and rvalid are held until rready is sampled high.
- Simultaneous read and write commit to the same register on one edge: the read returns the pre-write value.
- wr_stb and rd_stb are one-hot or zero, and never last longer than 1 cycle.

Test Plan:
- Reset, then AW 0x0C and W 0xDEADBEEF with wstrb 0xF in the same cycle, bready=1 → at the next cycle bvalid=1, bresp=00, ctrl_q[3]=0xDEADBEEF, wr_stb=0x0008 for 1 cycle.
- AW 0x04 at cycle 0, W 0x0000AB00 with wstrb 0x2 at cycle 3, ctrl_q[1]=0x11223344 beforehand → awready=0 during cycles 1-3; afterwards ctrl_q[1]=0x1122AB44 and bresp=00.
- Write to reg 2 with bready held low for 5 cycles → bvalid stays 1 and bresp stable; awready and wready stay 0; a second write is accepted only after the B handshake.
- RO_MASK bit 5 set, status_d[5]=0x12345678, AR 0x14 with rready low for 3 cycles → rvalid held, rdata=0x12345678, rresp=00, rd_stb[5] pulses once. Then write 0xFFFFFFFF to 0x14 → bresp=10, no wr_stb.
- NREGS=16, read and write to address 0x40 → rresp=11 with rdata=0; bresp=11; ctrl_q unchanged; no strobes.
- Assert bar_rst for 1 cycle while bvalid=1 and rvalid=1 → both 0 after the edge, ctrl_q all 0, readies 0 during reset and 1 on the following cycle.

Source files
------------

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle: five channels, with a responder (s) and requester (m) view.
interface axi4_lite_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport s (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input  bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input  rready
    );

    modport m (
        output awaddr, awprot, awvalid, input  awready,
        output wdata, wstrb, wvalid,    input  wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input  arready,
        input  rdata, rresp, rvalid,    output rready
    );
endinterface

// File: rtl/axi4_lite_reg_bank.sv
// AXI4-Lite register bank: NREGS x 32-bit control (RW) / status (RO) registers
// with per-register write/read strobes. One outstanding write and one outstanding
// read; the two paths are independent.
module axi4_lite_reg_bank #(
    parameter int                DW      = 32,
    parameter int                AW      = 32,
    parameter int                NREGS   = 16,
    parameter logic [NREGS-1:0]  RO_MASK = {NREGS{1'b0}}
) (
    input  logic                  bar_clk,
    input  logic                  bar_rst,
    axi4_lite_if.s                s,
    output logic [NREGS*DW-1:0]   ctrl_q,
    input  logic [NREGS*DW-1:0]   status_d,
    output logic [NREGS-1:0]      wr_stb,
    output logic [NREGS-1:0]      rd_stb
);
    localparam int IW = $clog2(NREGS);
    localparam int SW = DW / 8;

    // Write-path state: AW and W may arrive separately, so each gets a holding slot
    logic              aw_full_reg;
    logic [AW-1:0]     aw_addr_reg;
    logic              w_full_reg;
    logic [DW-1:0]     w_data_reg;
    logic [SW-1:0]     w_strb_reg;
    logic              bvalid_reg;
    logic [1:0]        bresp_reg;
    logic [NREGS-1:0]  wr_stb_reg;

    // Read-path state
    logic              rvalid_reg;
    logic [1:0]        rresp_reg;
    logic [DW-1:0]     rdata_reg;
    logic [NREGS-1:0]  rd_stb_reg;

    logic              aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [SW-1:0]     wr_strb;
    logic [IW-1:0]     wr_idx, rd_idx;
    logic              wr_oor, wr_ro, rd_oor;
    logic [DW-1:0]     rd_val;
    logic              unused_bits;

    // Readies are gated by reset directly so nothing is accepted while bar_rst is high
    assign s.awready = !aw_full_reg && !bvalid_reg && !bar_rst;
    assign s.wready  = !w_full_reg  && !bvalid_reg && !bar_rst;
    assign s.arready = !rvalid_reg  && !bar_rst;
    assign s.bvalid  = bvalid_reg;
    assign s.bresp   = bresp_reg;
    assign s.rvalid  = rvalid_reg;
    assign s.rresp   = rresp_reg;
    assign s.rdata   = rdata_reg;
    assign wr_stb    = wr_stb_reg;
    assign rd_stb    = rd_stb_reg;

    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid  && s.wready;
    assign ar_hs = s.arvalid && s.arready;

    // Use latched values if present, otherwise the ones handshaking this cycle
    assign wr_addr = aw_full_reg ? aw_addr_reg : s.awaddr;
    assign wr_data = w_full_reg  ? w_data_reg  : s.wdata;
    assign wr_strb = w_full_reg  ? w_strb_reg  : s.wstrb;
    assign commit  = (aw_full_reg || aw_hs) && (w_full_reg || w_hs);

    assign wr_idx = wr_addr[IW+1:2];
    assign wr_oor = |wr_addr[AW-1:IW+2];
    assign wr_ro  = RO_MASK[wr_idx];
    assign wr_ok  = commit && !wr_oor && !wr_ro;

    assign rd_idx = s.araddr[IW+1:2];
    assign rd_oor = |s.araddr[AW-1:IW+2];
    assign rd_val = rd_oor           ? '0 :
                    RO_MASK[rd_idx]  ? status_d[int'(rd_idx)*DW +: DW] :
                                       ctrl_q[int'(rd_idx)*DW +: DW];

    // Byte-lane addressing bits and protection attributes carry no meaning here
    assign unused_bits = ^{s.awprot, s.arprot, wr_addr[1:0], s.araddr[1:0]};

    // Write channel: latch AW/W, commit when both are present, hold B until bready
    always_ff @(posedge bar_clk) begin
        if (bar_rst) begin
            aw_full_reg <= 1'b0;
            aw_addr_reg <= '0;
            w_full_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
            wr_stb_reg  <= '0;
        end else begin
            wr_stb_reg <= '0;
            if (commit) begin
                aw_full_reg <= 1'b0;
                w_full_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_oor ? 2'b11 : (wr_ro ? 2'b10 : 2'b00);
                if (wr_ok) begin
                    wr_stb_reg <= NREGS'(1) << wr_idx;
                end
            end else begin
                if (aw_hs) begin
                    aw_full_reg <= 1'b1;
                    aw_addr_reg <= s.awaddr;
                end
                if (w_hs) begin
                    w_full_reg <= 1'b1;
                    w_data_reg <= s.wdata;
                    w_strb_reg <= s.wstrb;
                end
            end
            if (bvalid_reg && s.bready) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    // Read channel: capture data on AR handshake, hold R until rready
    always_ff @(posedge bar_clk) begin
        if (bar_rst) begin
            rvalid_reg <= 1'b0;
            rresp_reg  <= 2'b00;
            rdata_reg  <= '0;
            rd_stb_reg <= '0;
        end else begin
            rd_stb_reg <= '0;
            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_val;
                rresp_reg  <= rd_oor ? 2'b11 : 2'b00;
                if (!rd_oor) begin
                    rd_stb_reg <= NREGS'(1) << rd_idx;
                end
            end else if (rvalid_reg && s.rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    // Register storage: RW slots hold byte-enabled data, RO slots read as 0 on ctrl_q
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (RO_MASK[gi]) begin : g_ro
                assign ctrl_q[gi*DW +: DW] = '0;
            end else begin : g_rw
                localparam logic [IW-1:0] IDX = IW'(gi);
                logic [DW-1:0] reg_q;
                // Byte-masked update on a committed write that targets this slot
                always_ff @(posedge bar_clk) begin
                    if (bar_rst) begin
                        reg_q <= '0;
                    end else if (wr_ok && wr_idx == IDX) begin
                        for (int k = 0; k < SW; k++) begin
                            if (wr_strb[k]) begin
                                reg_q[8*k +: 8] <= wr_data[8*k +: 8];
                            end
                        end
                    end
                end
                assign ctrl_q[gi*DW +: DW] = reg_q;
            end
        end
    endgenerate
endmodule

// File: tb/tb_axi4_lite_reg_bank.sv
// Self-checking bench for axi4_lite_reg_bank (NREGS=16, register 5 read-only).
// Expected responses are queued when a request is driven and popped when the
// DUT presents the matching response.
module tb_axi4_lite_reg_bank;
    logic bar_clk = 1'b0;
    logic bar_rst;
    always #5 bar_clk = ~bar_clk;

    axi4_lite_if #(.DW(32), .AW(32)) bus ();
    logic [16*32-1:0] ctrl_q;
    logic [16*32-1:0] status_d;
    logic [15:0]      wr_stb;
    logic [15:0]      rd_stb;

    axi4_lite_reg_bank #(.DW(32), .AW(32), .NREGS(16), .RO_MASK(16'h0020)) dut (
        .bar_clk (bar_clk),
        .bar_rst (bar_rst),
        .s       (bus),
        .ctrl_q  (ctrl_q),
        .status_d(status_d),
        .wr_stb  (wr_stb),
        .rd_stb  (rd_stb)
    );

    int checks = 0;
    int failures = 0;
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];

    function automatic logic [31:0] reg_of(input int i);
        return ctrl_q[i*32 +: 32];
    endfunction

    task automatic cyc();
        @(posedge bar_clk);
        #1;
    endtask

    // Present AW and W together; return just after the edge where the last one is taken
    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        bit ad = 0, wd = 0, ta, tw;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = st;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        for (int n = 0; n < 50 && !(ad && wd); n++) begin
            ta = bus.awvalid && bus.awready;
            tw = bus.wvalid && bus.wready;
            cyc();
            if (ta) begin ad = 1; bus.awvalid = 1'b0; end
            if (tw) begin wd = 1; bus.wvalid = 1'b0; end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checks++;
        if (!(ad && wd)) begin failures++; $display("FAIL write_handshake addr=%h got=timeout want=accepted", a); end
    endtask

    task automatic drive_read(input logic [31:0] a);
        bit done = 0, t;
        bus.araddr = a; bus.arvalid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            t = bus.arready;
            cyc();
            if (t) done = 1;
        end
        bus.arvalid = 1'b0;
        checks++;
        if (!done) begin failures++; $display("FAIL read_handshake addr=%h got=timeout want=accepted", a); end
    endtask

    task automatic test_reset();
        bar_rst = 1'b1;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        status_d = '0;
        cyc(); cyc();
        checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin failures++; $display("FAIL reset_readies_low got=%b want=000", {bus.awready, bus.wready, bus.arready}); end
        bar_rst = 1'b0;
        #1;
        checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin failures++; $display("FAIL reset_readies_high got=%b want=111", {bus.awready, bus.wready, bus.arready}); end
        checks++; if ({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp} !== 6'b0) begin failures++; $display("FAIL reset_resp got=%b want=0", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}); end
        checks++; if (bus.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
        checks++; if (ctrl_q !== '0) begin failures++; $display("FAIL reset_ctrl_q got=%h want=0", ctrl_q); end
        checks++; if ({wr_stb, rd_stb} !== 32'h0) begin failures++; $display("FAIL reset_strobes got=%h want=0", {wr_stb, rd_stb}); end
    endtask

    task automatic test_same_cycle_write();
        logic [1:0] e;
        bus.bready = 1'b1;
        exp_b.push_back(2'b00);
        drive_write(32'h0C, 32'hDEADBEEF, 4'hF);
        e = exp_b.pop_front();
        checks++; if (bus.bvalid !== 1'b1) begin failures++; $display("FAIL w1_bvalid got=%b want=1", bus.bvalid); end
        checks++; if (bus.bresp !== e) begin failures++; $display("FAIL w1_bresp got=%b want=%b", bus.bresp, e); end
        checks++; if (reg_of(3) !== 32'hDEADBEEF) begin failures++; $display("FAIL w1_ctrl3 got=%h want=deadbeef", reg_of(3)); end
        checks++; if (wr_stb !== 16'h0008) begin failures++; $display("FAIL w1_wr_stb got=%h want=0008", wr_stb); end
        $display("write addr=0c data=deadbeef strb=f bresp=%b", bus.bresp);
        cyc();
        checks++; if ({bus.bvalid, wr_stb} !== 17'h0) begin failures++; $display("FAIL w1_after got=%h want=0", {bus.bvalid, wr_stb}); end
    endtask

    task automatic test_split_write();
        logic [1:0] e;
        bus.bready = 1'b1;
        exp_b.push_back(2'b00);
        drive_write(32'h04, 32'h11223344, 4'hF);
        e = exp_b.pop_front();
        checks++; if (bus.bresp !== e || reg_of(1) !== 32'h11223344) begin failures++; $display("FAIL split_pre got=%b/%h want=%b/11223344", bus.bresp, reg_of(1), e); end
        cyc();
        bus.awaddr = 32'h04; bus.awvalid = 1'b1;
        cyc();
        bus.awvalid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checks++; if (bus.awready !== 1'b0) begin failures++; $display("FAIL split_awready_c%0d got=%b want=0", k, bus.awready); end
            if (k == 3) begin
                bus.wdata = 32'h0000AB00; bus.wstrb = 4'h2; bus.wvalid = 1'b1;
                exp_b.push_back(2'b00);
            end
            cyc();
        end
        bus.wvalid = 1'b0;
        e = exp_b.pop_front();
        checks++; if (bus.bvalid !== 1'b1 || bus.bresp !== e) begin failures++; $display("FAIL split_b got=%b/%b want=1/%b", bus.bvalid, bus.bresp, e); end
        checks++; if (reg_of(1) !== 32'h1122AB44) begin failures++; $display("FAIL split_ctrl1 got=%h want=1122ab44", reg_of(1)); end
        $display("write addr=04 data=0000ab00 strb=2 bresp=%b ctrl1=%h", bus.bresp, reg_of(1));
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        bus.bready = 1'b0;
        exp_b.push_back(2'b00);
        drive_write(32'h08, 32'hA5A5A5A5, 4'hF);
        bus.awaddr = 32'h08; bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        exp_b.push_back(2'b00);
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.bvalid !== 1'b1 || bus.bresp !== exp_b[0]) begin failures++; $display("FAIL hold_b_c%0d got=%b/%b want=1/%b", k, bus.bvalid, bus.bresp, exp_b[0]); end
            checks++; if ({bus.awready, bus.wready} !== 2'b00) begin failures++; $display("FAIL hold_readies_c%0d got=%b want=00", k, {bus.awready, bus.wready}); end
            checks++; if (reg_of(2) !== 32'hA5A5A5A5) begin failures++; $display("FAIL hold_ctrl2_c%0d got=%h want=a5a5a5a5", k, reg_of(2)); end
            cyc();
        end
        bus.bready = 1'b1;
        e = exp_b.pop_front();
        checks++; if (bus.bresp !== e) begin failures++; $display("FAIL hold_bresp got=%b want=%b", bus.bresp, e); end
        $display("write addr=08 data=a5a5a5a5 bresp=%b (held 5 cycles)", bus.bresp);
        cyc();
        checks++; if (bus.bvalid !== 1'b0 || reg_of(2) !== 32'hA5A5A5A5) begin failures++; $display("FAIL b2b_gap got=%b/%h want=0/a5a5a5a5", bus.bvalid, reg_of(2)); end
        cyc();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        e = exp_b.pop_front();
        checks++; if (bus.bvalid !== 1'b1 || bus.bresp !== e || reg_of(2) !== 32'h5A5A5A5A) begin failures++; $display("FAIL b2b_second got=%b/%b/%h want=1/%b/5a5a5a5a", bus.bvalid, bus.bresp, reg_of(2), e); end
        $display("write addr=08 data=5a5a5a5a bresp=%b", bus.bresp);
        cyc();
    endtask

    task automatic test_ro_status();
        logic [33:0] er;
        logic [1:0]  e;
        int pulses = 0;
        status_d[5*32 +: 32] = 32'h12345678;
        bus.rready = 1'b0;
        exp_r.push_back({2'b00, 32'h12345678});
        drive_read(32'h14);
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.rvalid !== 1'b1 || {bus.rresp, bus.rdata} !== exp_r[0]) begin failures++; $display("FAIL ro_hold_c%0d got=%b/%b/%h want=1/%h", k, bus.rvalid, bus.rresp, bus.rdata, exp_r[0]); end
            if (rd_stb == 16'h0020) pulses++;
            else if (rd_stb !== 16'h0) pulses += 100;
            status_d[5*32 +: 32] = 32'h0;
            cyc();
        end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL ro_rd_stb_pulses got=%0d want=1", pulses); end
        bus.rready = 1'b1;
        er = exp_r.pop_front();
        $display("read addr=14 rresp=%b rdata=%h want=%h", bus.rresp, bus.rdata, er[31:0]);
        cyc();
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL ro_rvalid_drop got=%b want=0", bus.rvalid); end
        bus.bready = 1'b1;
        exp_b.push_back(2'b10);
        drive_write(32'h14, 32'hFFFFFFFF, 4'hF);
        e = exp_b.pop_front();
        checks++; if (bus.bresp !== e) begin failures++; $display("FAIL ro_bresp got=%b want=%b", bus.bresp, e); end
        checks++; if (wr_stb !== 16'h0 || reg_of(5) !== 32'h0) begin failures++; $display("FAIL ro_write_effect got=%h/%h want=0/0", wr_stb, reg_of(5)); end
        $display("write addr=14 data=ffffffff bresp=%b", bus.bresp);
        cyc();
    endtask

    task automatic test_out_of_range();
        logic [16*32-1:0] snap;
        logic [33:0] er;
        logic [1:0]  e;
        snap = ctrl_q;
        bus.rready = 1'b1; bus.bready = 1'b1;
        exp_r.push_back({2'b11, 32'h0});
        drive_read(32'h40);
        er = exp_r.pop_front();
        checks++; if (bus.rvalid !== 1'b1 || {bus.rresp, bus.rdata} !== er) begin failures++; $display("FAIL oor_read got=%b/%b/%h want=1/%h", bus.rvalid, bus.rresp, bus.rdata, er); end
        checks++; if (rd_stb !== 16'h0) begin failures++; $display("FAIL oor_rd_stb got=%h want=0", rd_stb); end
        $display("read addr=40 rresp=%b rdata=%h", bus.rresp, bus.rdata);
        cyc();
        exp_b.push_back(2'b11);
        drive_write(32'h40, 32'hCAFEF00D, 4'hF);
        e = exp_b.pop_front();
        checks++; if (bus.bresp !== e) begin failures++; $display("FAIL oor_bresp got=%b want=%b", bus.bresp, e); end
        checks++; if (wr_stb !== 16'h0 || ctrl_q !== snap) begin failures++; $display("FAIL oor_write_effect wr_stb=%h want=0", wr_stb); end
        $display("write addr=40 data=cafef00d bresp=%b", bus.bresp);
        cyc();
    endtask

    task automatic test_same_edge_rw();
        logic [33:0] er;
        logic [1:0]  e;
        bus.rready = 1'b1; bus.bready = 1'b1;
        bus.awaddr = 32'h08; bus.wdata = 32'h01020304; bus.wstrb = 4'hF; bus.araddr = 32'h08;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        exp_r.push_back({2'b00, 32'h5A5A5A5A});
        exp_b.push_back(2'b00);
        checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin failures++; $display("FAIL rw_readies got=%b want=111", {bus.awready, bus.wready, bus.arready}); end
        cyc();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        er = exp_r.pop_front();
        e = exp_b.pop_front();
        checks++; if ({bus.rresp, bus.rdata} !== er) begin failures++; $display("FAIL rw_read_old got=%b/%h want=%h", bus.rresp, bus.rdata, er); end
        checks++; if (bus.bresp !== e || reg_of(2) !== 32'h01020304) begin failures++; $display("FAIL rw_write got=%b/%h want=%b/01020304", bus.bresp, reg_of(2), e); end
        checks++; if (wr_stb !== 16'h0004 || rd_stb !== 16'h0004) begin failures++; $display("FAIL rw_strobes got=%h/%h want=0004/0004", wr_stb, rd_stb); end
        $display("read+write addr=08 rdata=%h ctrl2=%h", bus.rdata, reg_of(2));
        cyc();
    endtask

    task automatic test_reset_inflight();
        bus.bready = 1'b0; bus.rready = 1'b0;
        drive_write(32'h00, 32'h00000077, 4'hF);
        drive_read(32'h00);
        checks++; if ({bus.bvalid, bus.rvalid} !== 2'b11) begin failures++; $display("FAIL inflight_pre got=%b want=11", {bus.bvalid, bus.rvalid}); end
        bar_rst = 1'b1;
        #1;
        checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin failures++; $display("FAIL inflight_readies_rst got=%b want=000", {bus.awready, bus.wready, bus.arready}); end
        cyc();
        bar_rst = 1'b0;
        #1;
        checks++; if ({bus.bvalid, bus.rvalid} !== 2'b00) begin failures++; $display("FAIL inflight_valids got=%b want=00", {bus.bvalid, bus.rvalid}); end
        checks++; if (ctrl_q !== '0) begin failures++; $display("FAIL inflight_ctrl_q got=%h want=0", ctrl_q); end
        checks++; if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin failures++; $display("FAIL inflight_readies_after got=%b want=111", {bus.awready, bus.wready, bus.arready}); end
        $display("reset during in-flight B/R: bvalid=%b rvalid=%b", bus.bvalid, bus.rvalid);
        cyc();
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_split_write();
        test_back_to_back();
        test_ro_status();
        test_out_of_range();
        test_same_edge_rw();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
